// File: rtl/ide_sector_ctl.sv
// IDE sector-transfer sequencer: taskfile setup, status polling, data moves.
// Optional IDE_TIMEOUT_EN bounds every status-poll phase to TIMEOUT_POLLS reads.
module ide_sector_ctl #(
  parameter int TIMEOUT_POLLS = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic        cmd_write,
  input  logic [27:0] cmd_lba,
  input  logic [7:0]  cmd_nsect,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  status_q,
  output logic        ata_rd,
  output logic        ata_wr,
  output logic [4:0]  ata_addr,
  output logic [15:0] ata_wdata,
  input  logic [15:0] ata_rdata,
  input  logic        ata_done,
  output logic [7:0]  buf_addr,
  output logic        buf_we,
  output logic [15:0] buf_wdata,
  output logic        buf_re,
  input  logic [15:0] buf_rdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_POLL_BSY, S_CNT, S_LBA0,
    S_LBA1, S_LBA2, S_DRV, S_CMD,
    S_POLL_DRQ, S_XFER, S_POLL_END, S_FIN
  } state_t;

  localparam logic [4:0] A_DATA = 5'h10;
  localparam logic [4:0] A_CNT  = 5'h12;
  localparam logic [4:0] A_LBA0 = 5'h13;
  localparam logic [4:0] A_LBA1 = 5'h14;
  localparam logic [4:0] A_LBA2 = 5'h15;
  localparam logic [4:0] A_DRV  = 5'h16;
  localparam logic [4:0] A_CMD  = 5'h17;

  state_t      r_state;
  logic        r_write;
  logic [27:0] r_lba;
  logic [7:0]  r_nsect;
  logic [7:0]  r_sect;
  logic        r_gap;
  logic [1:0]  r_xstep;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_status;
  logic        r_ata_rd;
  logic        r_ata_wr;
  logic [4:0]  r_ata_addr;
  logic [15:0] r_ata_wdata;
  logic [7:0]  r_buf_addr;
  logic        r_buf_we;
  logic        r_buf_re;
  logic [15:0] r_buf_wdata;

  logic [4:0]  w_waddr;
  logic [15:0] w_wdata;
  state_t      w_wnext;
  state_t      w_xnext;
  logic        w_bsy;
  logic        w_drq;
  logic        w_serr;
  logic        w_tmo;

  assign w_bsy  = ata_rdata[7];
  assign w_drq  = ata_rdata[3];
  assign w_serr = ata_rdata[0];

  assign w_xnext = (r_sect != 8'd1) ? S_POLL_DRQ :
                   (r_write ? S_POLL_END : S_FIN);

  always_comb begin
    w_waddr = A_CNT;
    w_wdata = {8'h00, r_nsect};
    w_wnext = S_LBA0;
    unique case (r_state)
      S_LBA0: begin
        w_waddr = A_LBA0;
        w_wdata = {8'h00, r_lba[7:0]};
        w_wnext = S_LBA1;
      end
      S_LBA1: begin
        w_waddr = A_LBA1;
        w_wdata = {8'h00, r_lba[15:8]};
        w_wnext = S_LBA2;
      end
      S_LBA2: begin
        w_waddr = A_LBA2;
        w_wdata = {8'h00, r_lba[23:16]};
        w_wnext = S_DRV;
      end
      S_DRV: begin
        w_waddr = A_DRV;
        w_wdata = {8'h00, 4'hE, r_lba[27:24]};
        w_wnext = S_CMD;
      end
      S_CMD: begin
        w_waddr = A_CMD;
        w_wdata = r_write ? 16'h0030 : 16'h0020;
        w_wnext = S_POLL_DRQ;
      end
      default: ;
    endcase
  end

`ifdef IDE_TIMEOUT_EN
  localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_POLLS - 1);
  logic [15:0] r_polls;
  logic        w_poll_st;
  logic        w_poll_rd;

  assign w_poll_st = (r_state == S_POLL_BSY) ||
                     (r_state == S_POLL_DRQ) ||
                     (r_state == S_POLL_END);
  assign w_poll_rd = r_ata_rd && ata_done;
  assign w_tmo     = (r_polls == LP_TMO_LAST);

  // Held at zero outside poll states, so every poll phase starts fresh.
  always_ff @(posedge clk) begin
    if (reset)
      r_polls <= '0;
    else if (!w_poll_st)
      r_polls <= '0;
    else if (w_poll_rd)
      r_polls <= r_polls + 16'd1;
  end
`else
  assign w_tmo = (TIMEOUT_POLLS < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_lba       <= '0;
      r_nsect     <= '0;
      r_sect      <= '0;
      r_gap       <= 1'b0;
      r_xstep     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_status    <= '0;
      r_ata_rd    <= 1'b0;
      r_ata_wr    <= 1'b0;
      r_ata_addr  <= '0;
      r_ata_wdata <= '0;
      r_buf_addr  <= '0;
      r_buf_we    <= 1'b0;
      r_buf_re    <= 1'b0;
      r_buf_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      // Read-path word lands in the buffer, then the index advances.
      if (r_buf_we) begin
        r_buf_we   <= 1'b0;
        r_buf_addr <= r_buf_addr + 8'd1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (cmd_start) begin
            r_write    <= cmd_write;
            r_lba      <= cmd_lba;
            r_nsect    <= cmd_nsect;
            r_sect     <= cmd_nsect;
            r_err      <= 1'b0;
            r_buf_addr <= '0;
            r_gap      <= 1'b0;
            r_xstep    <= '0;
            if (cmd_nsect == 8'd0) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_POLL_BSY;
            end
          end
        end
        S_POLL_BSY, S_POLL_DRQ, S_POLL_END: begin
          if (r_gap) begin
            r_gap <= 1'b0;
          end else if (!r_ata_rd) begin
            r_ata_rd   <= 1'b1;
            r_ata_addr <= A_CMD;
          end else if (ata_done) begin
            r_ata_rd <= 1'b0;
            r_gap    <= 1'b1;
            r_status <= ata_rdata[7:0];
            if (w_bsy) begin
              if (w_tmo) begin
                r_err   <= 1'b1;
                r_state <= S_FIN;
              end
            end else if (r_state == S_POLL_BSY) begin
              r_state <= S_CNT;
            end else if (r_state == S_POLL_END) begin
              r_err   <= w_serr;
              r_state <= S_FIN;
            end else if (w_serr) begin
              r_err   <= 1'b1;
              r_state <= S_FIN;
            end else if (w_drq) begin
              r_buf_addr <= '0;
              r_xstep    <= '0;
              r_state    <= S_XFER;
            end else if (w_tmo) begin
              r_err   <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_CNT, S_LBA0, S_LBA1, S_LBA2, S_DRV, S_CMD: begin
          if (r_gap) begin
            r_gap <= 1'b0;
          end else if (!r_ata_wr) begin
            r_ata_wr    <= 1'b1;
            r_ata_addr  <= w_waddr;
            r_ata_wdata <= w_wdata;
          end else if (ata_done) begin
            r_ata_wr <= 1'b0;
            r_gap    <= 1'b1;
            r_state  <= w_wnext;
          end
        end
        S_XFER: begin
          if (r_gap) begin
            r_gap <= 1'b0;
          end else if (r_ata_rd || r_ata_wr) begin
            if (ata_done) begin
              r_ata_rd <= 1'b0;
              r_ata_wr <= 1'b0;
              r_gap    <= 1'b1;
              if (r_write) begin
                r_buf_addr <= r_buf_addr + 8'd1;
              end else begin
                r_buf_we    <= 1'b1;
                r_buf_wdata <= ata_rdata;
              end
              if (r_buf_addr == 8'hFF) begin
                r_sect  <= r_sect - 8'd1;
                r_state <= w_xnext;
              end
            end
          end else if (!r_write) begin
            r_ata_rd   <= 1'b1;
            r_ata_addr <= A_DATA;
          end else begin
            unique case (r_xstep)
              2'd0: begin
                r_buf_re <= 1'b1;
                r_xstep  <= 2'd1;
              end
              2'd1: begin
                r_buf_re <= 1'b0;
                r_xstep  <= 2'd2;
              end
              default: begin
                r_ata_wr    <= 1'b1;
                r_ata_addr  <= A_DATA;
                r_ata_wdata <= buf_rdata;
                r_xstep     <= 2'd0;
              end
            endcase
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign status_q  = r_status;
  assign ata_rd    = r_ata_rd;
  assign ata_wr    = r_ata_wr;
  assign ata_addr  = r_ata_addr;
  assign ata_wdata = r_ata_wdata;
  assign buf_addr  = r_buf_addr;
  assign buf_we    = r_buf_we;
  assign buf_wdata = r_buf_wdata;
  assign buf_re    = r_buf_re;

endmodule

// File: tb/tb_ide_sector_ctl.sv
// Bench for ide_sector_ctl: register-engine, status and buffer models
// with expected taskfile/data traffic queued and compared per scenario.
module tb_ide_sector_ctl;

`ifdef IDE_TIMEOUT_EN
  localparam int TB_TMO = 8;
`else
  localparam int TB_TMO = 65535;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic        cmd_write = 1'b0;
  logic [27:0] cmd_lba = '0;
  logic [7:0]  cmd_nsect = '0;
  logic        busy, done, err;
  logic [7:0]  status_q;
  logic        ata_rd, ata_wr;
  logic [4:0]  ata_addr;
  logic [15:0] ata_wdata;
  logic [15:0] ata_rdata = '0;
  logic        ata_done = 1'b0;
  logic [7:0]  buf_addr;
  logic        buf_we, buf_re;
  logic [15:0] buf_wdata;
  logic [15:0] buf_rdata = '0;

  ide_sector_ctl #(.TIMEOUT_POLLS(TB_TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_write(cmd_write),
    .cmd_lba(cmd_lba), .cmd_nsect(cmd_nsect),
    .busy(busy), .done(done), .err(err), .status_q(status_q),
    .ata_rd(ata_rd), .ata_wr(ata_wr), .ata_addr(ata_addr),
    .ata_wdata(ata_wdata), .ata_rdata(ata_rdata), .ata_done(ata_done),
    .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata),
    .buf_re(buf_re), .buf_rdata(buf_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [4:0] a; logic [15:0] d; } wr_t;
  typedef struct packed { logic [7:0] a; logic [15:0] d; } bw_t;

  wr_t exp_wr[$];
  wr_t obs_wr[$];
  bw_t exp_buf[$];
  bw_t obs_buf[$];
  logic [7:0] sts_q[$];
  logic [7:0] sts_def = 8'h50;

  int n_vec = 0;
  int n_err = 0;
  int n_stat = 0, n_acc = 0, n_done = 0, viol = 0;
  int lowcnt = 99;
  bit prev_req = 1'b0;
  int rd_idx = 0;
  int eng_cnt = 0;
  bit eng_busy = 1'b0;

  function automatic logic [15:0] disk_word(input int i);
    return 16'(i * 259) ^ 16'h5A00;
  endfunction

  // Register access engine: fixed latency, one-cycle done pulse.
  always @(posedge clk) begin
    ata_done <= 1'b0;
    if (cmd_start) rd_idx <= 0;
    if (reset) begin
      eng_busy <= 1'b0;
      eng_cnt  <= 0;
    end else if (!eng_busy && !ata_done && (ata_rd || ata_wr)) begin
      eng_busy <= 1'b1;
      eng_cnt  <= 1;
    end else if (eng_busy) begin
      if (eng_cnt == 0) begin
        eng_busy <= 1'b0;
        ata_done <= 1'b1;
        if (ata_rd && ata_addr == 5'h17) begin
          if (sts_q.size() > 0) ata_rdata <= {8'h00, sts_q.pop_front()};
          else ata_rdata <= {8'h00, sts_def};
        end else if (ata_rd && ata_addr == 5'h10) begin
          ata_rdata <= disk_word(rd_idx);
          rd_idx    <= rd_idx + 1;
        end else begin
          ata_rdata <= 16'h0000;
        end
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  always @(posedge clk)
    if (buf_re) buf_rdata <= {8'h00, buf_addr} ^ 16'hA5A5;

  always @(negedge clk) begin
    if (ata_rd && ata_wr) viol++;
    if (ata_rd || ata_wr) begin
      if (!prev_req && lowcnt < 2) viol++;
      lowcnt = 0;
      n_acc++;
    end else if (lowcnt < 99) begin
      lowcnt++;
    end
    prev_req = ata_rd || ata_wr;
    if (ata_done && ata_wr) obs_wr.push_back(wr_t'({ata_addr, ata_wdata}));
    if (ata_done && ata_rd && ata_addr == 5'h17) n_stat++;
    if (buf_we) obs_buf.push_back(bw_t'({buf_addr, buf_wdata}));
    if (done) n_done++;
  end

  task automatic clear_sb();
    exp_wr.delete();
    obs_wr.delete();
    exp_buf.delete();
    obs_buf.delete();
    sts_q.delete();
    sts_def = 8'h50;
    n_stat = 0;
    n_acc = 0;
    n_done = 0;
    viol = 0;
  endtask

  task automatic push_tf(input bit w, input logic [27:0] lba,
                         input logic [7:0] n);
    exp_wr.push_back(wr_t'({5'h12, 8'h00, n}));
    exp_wr.push_back(wr_t'({5'h13, 8'h00, lba[7:0]}));
    exp_wr.push_back(wr_t'({5'h14, 8'h00, lba[15:8]}));
    exp_wr.push_back(wr_t'({5'h15, 8'h00, lba[23:16]}));
    exp_wr.push_back(wr_t'({5'h16, 8'h00, 4'hE, lba[27:24]}));
    exp_wr.push_back(wr_t'({5'h17, w ? 16'h0030 : 16'h0020}));
  endtask

  task automatic push_rd_words(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      a = 8'(i);
      exp_buf.push_back(bw_t'({a, disk_word(i)}));
    end
  endtask

  task automatic start_cmd(input bit w, input logic [27:0] lba,
                           input logic [7:0] n);
    @(negedge clk);
    cmd_write = w;
    cmd_lba   = lba;
    cmd_nsect = n;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output bit e,
                           output logic [7:0] sq);
    ok = 1'b0;
    e  = 1'b0;
    sq = 8'h00;
    for (int i = 0; i < 30000; i++) begin
      if (done) begin
        ok = 1'b1;
        e  = err;
        sq = status_q;
        break;
      end
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, err} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags got %b want 000", {busy, done, err});
    end
    n_vec++;
    if (status_q !== 8'h00) begin
      n_err++;
      $display("FAIL reset_status got %h want 00", status_q);
    end
    n_vec++;
    if ({ata_rd, ata_wr, ata_addr, ata_wdata} !== 23'd0) begin
      n_err++;
      $display("FAIL reset_ata got %b%b %h %h want 0 0 00 0000",
               ata_rd, ata_wr, ata_addr, ata_wdata);
    end
    n_vec++;
    if ({buf_we, buf_re, buf_addr} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_buf got %b%b %h want 0 0 00",
               buf_we, buf_re, buf_addr);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_sector();
    bit ok, e;
    logic [7:0] sq;
    clear_sb();
    sts_q = '{8'h80, 8'h50, 8'h58};
    push_tf(1'b0, 28'h0123456, 8'd1);
    push_rd_words(256);
    start_cmd(1'b0, 28'h0123456, 8'd1);
    wait_done(ok, e, sq);
    n_vec++;
    if (ok !== 1'b1 || e !== 1'b0) begin
      n_err++;
      $display("FAIL rd_done got ok=%b err=%b want ok=1 err=0", ok, e);
    end
    n_vec++;
    if (sq !== 8'h58 || n_stat !== 3 || n_done !== 1) begin
      n_err++;
      $display("FAIL rd_status got sq=%h reads=%0d dones=%0d want 58 3 1",
               sq, n_stat, n_done);
    end
    n_vec++;
    if (obs_wr.size() !== exp_wr.size() || obs_buf.size() !== 256) begin
      n_err++;
      $display("FAIL rd_counts got wr=%0d buf=%0d want wr=%0d buf=256",
               obs_wr.size(), obs_buf.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      wr_t x, y;
      x = exp_wr.pop_front();
      y = obs_wr.pop_front();
      n_vec++;
      if (y !== x) begin
        n_err++;
        $display("FAIL rd_taskfile got %h<-%h want %h<-%h", y.a, y.d, x.a, x.d);
      end
    end
    while (exp_buf.size() > 0 && obs_buf.size() > 0) begin
      bw_t x, y;
      x = exp_buf.pop_front();
      y = obs_buf.pop_front();
      n_vec++;
      if (y !== x) begin
        n_err++;
        $display("FAIL rd_buf got [%h]=%h want [%h]=%h", y.a, y.d, x.a, x.d);
      end
    end
    n_vec++;
    if (viol !== 0) begin
      n_err++;
      $display("FAIL rd_protocol got %0d violations want 0", viol);
    end
  endtask

  task automatic test_write_sectors();
    bit ok, e;
    logic [7:0] sq;
    clear_sb();
    sts_q = '{8'h50, 8'h58, 8'h58, 8'h50};
    push_tf(1'b1, 28'hFEDCBA9, 8'd2);
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 256; w++)
        exp_wr.push_back(wr_t'({5'h10, 16'(w) ^ 16'hA5A5}));
    start_cmd(1'b1, 28'hFEDCBA9, 8'd2);
    wait_done(ok, e, sq);
    n_vec++;
    if (ok !== 1'b1 || e !== 1'b0) begin
      n_err++;
      $display("FAIL wr_done got ok=%b err=%b want ok=1 err=0", ok, e);
    end
    n_vec++;
    if (n_stat !== 4 || n_done !== 1 || obs_buf.size() !== 0) begin
      n_err++;
      $display("FAIL wr_polls got reads=%0d dones=%0d bufwe=%0d want 4 1 0",
               n_stat, n_done, obs_buf.size());
    end
    n_vec++;
    if (obs_wr.size() !== exp_wr.size()) begin
      n_err++;
      $display("FAIL wr_count got %0d want %0d", obs_wr.size(), exp_wr.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      wr_t x, y;
      x = exp_wr.pop_front();
      y = obs_wr.pop_front();
      n_vec++;
      if (y !== x) begin
        n_err++;
        $display("FAIL wr_data got %h<-%h want %h<-%h", y.a, y.d, x.a, x.d);
      end
    end
    n_vec++;
    if (viol !== 0) begin
      n_err++;
      $display("FAIL wr_protocol got %0d violations want 0", viol);
    end
  endtask

  task automatic test_zero_count();
    clear_sb();
    start_cmd(1'b0, 28'h0000010, 8'd0);
    n_vec++;
    if (done !== 1'b1 || err !== 1'b1) begin
      n_err++;
      $display("FAIL zero_done got done=%b err=%b want 1 1", done, err);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL zero_pulse got done=%b want 0", done);
    end
    repeat (10) @(negedge clk);
    n_vec++;
    if (n_acc !== 0 || n_done !== 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_quiet got acc=%0d dones=%0d busy=%b want 0 1 0",
               n_acc, n_done, busy);
    end
  endtask

  task automatic test_error_status();
    bit ok, e;
    logic [7:0] sq;
    clear_sb();
    sts_q = '{8'h50, 8'h51};
    push_tf(1'b0, 28'h0000001, 8'd3);
    start_cmd(1'b0, 28'h0000001, 8'd3);
    wait_done(ok, e, sq);
    n_vec++;
    if (ok !== 1'b1 || e !== 1'b1 || sq !== 8'h51) begin
      n_err++;
      $display("FAIL err_done got ok=%b err=%b sq=%h want 1 1 51", ok, e, sq);
    end
    n_vec++;
    if (obs_buf.size() !== 0 || obs_wr.size() !== 6 || n_stat !== 2) begin
      n_err++;
      $display("FAIL err_traffic got buf=%0d wr=%0d reads=%0d want 0 6 2",
               obs_buf.size(), obs_wr.size(), n_stat);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, e, found;
    logic [7:0] sq;
    clear_sb();
    sts_q = '{8'h50, 8'h58};
    start_cmd(1'b0, 28'h0ABCDEF, 8'd1);
    found = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (ata_rd && ata_addr == 5'h10 && buf_addr == 8'd100) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (found !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reach got found=%b want 1", found);
    end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ata_rd !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_abort got rd=%b busy=%b want 0 0", ata_rd, busy);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_vec++;
    if (n_done !== 0) begin
      n_err++;
      $display("FAIL mid_nodone got %0d want 0", n_done);
    end
    clear_sb();
    sts_q = '{8'h50, 8'h58};
    push_tf(1'b0, 28'h9876543, 8'd1);
    push_rd_words(256);
    start_cmd(1'b0, 28'h9876543, 8'd1);
    wait_done(ok, e, sq);
    n_vec++;
    if (ok !== 1'b1 || e !== 1'b0 || obs_buf.size() !== 256) begin
      n_err++;
      $display("FAIL mid_rerun got ok=%b err=%b buf=%0d want 1 0 256",
               ok, e, obs_buf.size());
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      wr_t x, y;
      x = exp_wr.pop_front();
      y = obs_wr.pop_front();
      n_vec++;
      if (y !== x) begin
        n_err++;
        $display("FAIL mid_taskfile got %h<-%h want %h<-%h", y.a, y.d, x.a, x.d);
      end
    end
    while (exp_buf.size() > 0 && obs_buf.size() > 0) begin
      bw_t x, y;
      x = exp_buf.pop_front();
      y = obs_buf.pop_front();
      n_vec++;
      if (y !== x) begin
        n_err++;
        $display("FAIL mid_buf got [%h]=%h want [%h]=%h", y.a, y.d, x.a, x.d);
      end
    end
  endtask

`ifdef IDE_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, e;
    logic [7:0] sq;
    clear_sb();
    sts_def = 8'h80;
    start_cmd(1'b0, 28'h0000020, 8'd1);
    wait_done(ok, e, sq);
    n_vec++;
    if (ok !== 1'b1 || e !== 1'b1 || n_stat !== 8) begin
      n_err++;
      $display("FAIL tmo_polls got ok=%b err=%b reads=%0d want 1 1 8",
               ok, e, n_stat);
    end
    sts_def = 8'h50;
  endtask
`endif

  initial begin
    test_reset();
    test_read_sector();
    test_write_sectors();
    test_zero_count();
    test_error_status();
    test_reset_mid();
`ifdef IDE_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ide_sector_ctl.md
Name: ide_sector_ctl

Overview:
- Sector-transfer sequencer for the IDE register-access engine.
- Takes one host command (read/write, 28-bit LBA, sector count) and drives register cycles to complete it: status polls, taskfile loads, command issue, 256-word data-register transfers per sector.
- Streams data to/from a synchronous sector buffer.
- Sits between the disk-controller register front end (e.g. an RK/RL emulation) and the IDE access engine.

Parameters:
- TIMEOUT_POLLS, 65535: maximum status reads per poll phase before a timeout error (used only with IDE_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_start  in  1  one-cycle start pulse; ignored while busy=1
- cmd_write  in  1  1=WRITE SECTORS (0x30), 0=READ SECTORS (0x20); sampled on cmd_start
- cmd_lba  in  28  starting LBA; sampled on cmd_start
- cmd_nsect  in  8  sector count 1..255; sampled on cmd_start
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command end
- err  out  1  error flag for the last command; valid from done, held until next cmd_start
- status_q  out  8  last ATA status byte read
- ata_rd  out  1  register read request to the access engine
- ata_wr  out  1  register write request
- ata_addr  out  5  {cs[1:0], da[2:0]}; this block uses only 5'h10..5'h17
- ata_wdata  out  16  write data to the engine
- ata_rdata  in  16  read data from the engine; valid while ata_done=1
- ata_done  in  1  engine cycle-complete pulse
- buf_addr  out  8  word index within the current sector
- buf_we  out  1  read-path buffer write strobe
- buf_wdata  out  16  read-path word
- buf_re  out  1  write-path buffer read strobe
- buf_rdata  in  16  write-path word, valid the cycle after buf_re

Behaviour:
- Reset values: busy=0, done=0, err=0, status_q=0, ata_rd=0, ata_wr=0, ata_addr=0, ata_wdata=0, buf_we=0, buf_re=0, buf_addr=0, state=IDLE.
- Reset mid-operation drops ata_rd/ata_wr at the next edge and aborts the command with no done pulse.
- Access rule:
  - Raise ata_rd or ata_wr with ata_addr and ata_wdata stable.
  - Hold until the edge on which ata_done=1, then clear the request at that edge.
  - Keep requests low for at least 2 cycles before the next access (the engine re-triggers if a request is high on return to idle).
  - Never raise ata_rd and ata_wr together.
- cmd_nsect=0: no bus activity; done and err=1 are raised 1 cycle after cmd_start.
- State machine, one register access per state unless noted:
  - IDLE: on cmd_start, latch the command, busy=1, go to POLL_BSY.
  - POLL_BSY: read 5'h17 and load status_q. If BSY (bit7)=1, repeat; else go to CNT.
  - CNT: write cmd_nsect to 5'h12, then LBA0.
  - LBA0: write lba[7:0] to 5'h13, then LBA1.
  - LBA1: write lba[15:8] to 5'h14, then LBA2.
  - LBA2: write lba[23:16] to 5'h15, then DRV.
  - DRV: write {4'hE, lba[27:24]} to 5'h16, then CMD.
  - CMD: write 0x20 or 0x30 to 5'h17, then POLL_DRQ.
  - POLL_DRQ: read 5'h17. BSY=1 repeats the read. ERR (bit0)=1 goes to FIN with err=1. DRQ (bit3)=1 goes to XFER with buf_addr=0.
  - XFER, read command: read 5'h10. On ata_done, buf_wdata<=ata_rdata and buf_we=1 for the next single cycle at the current buf_addr, then increment buf_addr.
  - XFER, write command: pulse buf_re for 1 cycle, latch buf_rdata the next cycle, then write it to 5'h10.
  - XFER exit: after word 255, buf_addr wraps to 0 and the sector counter decrements. Next state is POLL_DRQ if sectors remain, otherwise FIN for reads and POLL_END for writes.
  - POLL_END: read 5'h17 until BSY=0. Go to FIN; err=ERR bit.
  - FIN: done=1 for 1 cycle, busy=0, go to IDLE.
- Word and sector counters are 8 bits. The sector counter loads cmd_nsect and hits 0 only after the final sector.

Optional Feature:
- IDE_TIMEOUT_EN defined:
  - A 16-bit poll counter clears on entry to POLL_BSY, POLL_DRQ and POLL_END.
  - It increments on each status read.
  - Reaching TIMEOUT_POLLS goes to FIN with err=1.
- Undefined: polls are unbounded and no counter logic is present.

Test Plan:
- Read, lba=0x0123456, nsect=1, status model returns 0x80,0x50 then 0x58: taskfile writes 12<-01, 13<-56, 14<-34, 15<-12, 16<-E0, 17<-20; 256 buf_we with buf_addr 0..255 and data matching the disk model; one done, err=0.
- Write, nsect=2, buf_rdata=addr^0xA5A5: 512 data writes to 5'h10 in order, 17<-30, POLL_END seen; done with err=0.
- After command, status returns 0x51 (ERR): no data transfer; done with err=1 and status_q=0x51.
- cmd_nsect=0: no ata_rd/ata_wr ever asserted; done and err=1 one cycle later.
- Reset asserted mid-XFER on word 100: ata_rd low next edge, busy=0, no done; a new command then completes normally.
- IDE_TIMEOUT_EN with TIMEOUT_POLLS=8 and status stuck at 0x80: exactly 8 status reads, then done with err=1.
